// File: rtl/gpio_conditioner_channel.sv
// One GPIO channel: loopback mux, synchroniser, debounce filter and sticky edge interrupt.
module gpio_conditioner_channel #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pad_i,
    input  logic out_i,
    input  logic oe_i,
    input  logic rise_en_i,
    input  logic fall_en_i,
    input  logic clear_i,
    output logic level_o,
    output logic pending_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                   raw;
    logic                   sync;
    logic                   toggle;
    logic                   rise;
    logic                   fall;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   pending_q, pending_d;

    always_comb begin
        raw    = oe_i ? out_i : pad_i;
        sync_d = {sync_q[SYNC_STAGES-2:0], raw};
        sync   = sync_q[SYNC_STAGES-1];
        toggle = (sync != stable_q) && (cnt_q == CNT_LAST);

        if (sync == stable_q || toggle) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        stable_d = stable_q ^ toggle;

        // Events are qualified by the pre-toggle stable value; set beats clear.
        rise      = toggle & ~stable_q;
        fall      = toggle & stable_q;
        pending_d = (rise & rise_en_i) | (fall & fall_en_i) | (pending_q & ~clear_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            stable_q  <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            pending_q <= pending_d;
        end
    end

    assign level_o   = stable_q;
    assign pending_o = pending_q;

endmodule

// File: rtl/gpio_conditioner.sv
// GPIO input conditioner: per-pin channels plus the aggregated interrupt line.
module gpio_conditioner #(
    parameter int unsigned GPIO_WIDTH      = 8,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [GPIO_WIDTH-1:0] gpio_pad_in,
    input  logic [GPIO_WIDTH-1:0] gpio_output,
    input  logic [GPIO_WIDTH-1:0] gpio_oe,
    input  logic [GPIO_WIDTH-1:0] irq_rise_en,
    input  logic [GPIO_WIDTH-1:0] irq_fall_en,
    input  logic [GPIO_WIDTH-1:0] irq_clear,
    output logic [GPIO_WIDTH-1:0] gpio_input,
    output logic [GPIO_WIDTH-1:0] irq_pending,
    output logic                  irq
);

    if (GPIO_WIDTH < 1 || GPIO_WIDTH > 32 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("gpio_conditioner: illegal parameters GPIO_WIDTH=%0d SYNC_STAGES=%0d DEBOUNCE_CYCLES=%0d",
               GPIO_WIDTH, SYNC_STAGES, DEBOUNCE_CYCLES);
    end

    for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_chan
        gpio_conditioner_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .clk_i     (clock),
            .rst_i     (reset),
            .pad_i     (gpio_pad_in[i]),
            .out_i     (gpio_output[i]),
            .oe_i      (gpio_oe[i]),
            .rise_en_i (irq_rise_en[i]),
            .fall_en_i (irq_fall_en[i]),
            .clear_i   (irq_clear[i]),
            .level_o   (gpio_input[i]),
            .pending_o (irq_pending[i])
        );
    end

    assign irq = |irq_pending;

endmodule

// File: tb/tb_gpio_conditioner.sv
// Bench for gpio_conditioner: directed scenarios plus random stimulus against a window-based reference model.
module tb_gpio_conditioner;

    localparam int W = 4;
    localparam int S = 2;
    localparam int D = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] pad, gout, oe, ren, fen, clr;
    logic [W-1:0] gin, pend;
    logic         irq;

    always #5 clock = ~clock;

    gpio_conditioner #(
        .GPIO_WIDTH      (W),
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .gpio_pad_in (pad),
        .gpio_output (gout),
        .gpio_oe     (oe),
        .irq_rise_en (ren),
        .irq_fall_en (fen),
        .irq_clear   (clr),
        .gpio_input  (gin),
        .irq_pending (pend),
        .irq         (irq)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: raw level history per edge; a pin flips once its last D
    // synchronised samples (all taken after the latest reset) disagree with it.
    int           n  = 0;
    int           lr = 0;
    logic [W-1:0] raw_hist [0:8191];
    logic [W-1:0] m_in   = '0;
    logic [W-1:0] m_pend = '0;

    function automatic logic sync_at(int m, int i);
        if (m - S > lr) return raw_hist[m-S][i];
        return 1'b0;
    endfunction

    task automatic step();
        logic [W-1:0] nxt_in, nxt_pend;
        bit           all_diff;
        @(posedge clock);
        n++;
        raw_hist[n] = (oe & gout) | (~oe & pad);
        if (reset) begin
            m_in   = '0;
            m_pend = '0;
            lr     = n;
        end else begin
            nxt_in   = m_in;
            nxt_pend = m_pend;
            for (int i = 0; i < W; i++) begin
                all_diff = 1'b1;
                for (int k = 0; k < D; k++) begin
                    int m = n - k;
                    if (m <= lr || sync_at(m, i) == m_in[i]) all_diff = 1'b0;
                end
                if (all_diff) nxt_in[i] = ~m_in[i];
                if (all_diff && ((nxt_in[i] && ren[i]) || (!nxt_in[i] && fen[i])))
                    nxt_pend[i] = 1'b1;
                else if (clr[i])
                    nxt_pend[i] = 1'b0;
            end
            m_in   = nxt_in;
            m_pend = nxt_pend;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pad   = 4'hF;
        step();
        step();
        vectors++;
        if (gin !== 4'h0 || pend !== 4'h0 || irq !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: gpio_input=%h irq_pending=%h irq=%b, expected 0 0 0", gin, pend, irq);
        end
        reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            vectors++;
            if (gin !== m_in || pend !== m_pend || irq !== (|m_pend)) begin
                miscompares++;
                $display("FAIL reset_release_%0d: in=%h pend=%h irq=%b, expected %h %h %b", k, gin, pend, irq, m_in, m_pend, |m_pend);
            end
            if (k == 5) begin
                vectors++;
                if (gin !== 4'h0) begin
                    miscompares++;
                    $display("FAIL reset_release_early: gpio_input=%h, expected 0", gin);
                end
            end
            if (k == 6) begin
                vectors++;
                if (gin !== 4'hF) begin
                    miscompares++;
                    $display("FAIL reset_release_edge6: gpio_input=%h, expected f", gin);
                end
            end
        end
    endtask

    task automatic test_rise();
        pad = 4'h0;
        for (int k = 0; k < 8; k++) step();
        vectors++;
        if (gin !== 4'h0 || pend !== 4'h0) begin
            miscompares++;
            $display("FAIL rise_settle: in=%h pend=%h, expected 0 0", gin, pend);
        end
        ren    = 4'b0001;
        pad[0] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            vectors++;
            if (gin !== m_in || pend !== m_pend || irq !== (|m_pend)) begin
                miscompares++;
                $display("FAIL rise_seq_%0d: in=%h pend=%h irq=%b, expected %h %h %b", k, gin, pend, irq, m_in, m_pend, |m_pend);
            end
        end
        vectors++;
        if (gin[0] !== 1'b1 || pend[0] !== 1'b1 || irq !== 1'b1) begin
            miscompares++;
            $display("FAIL rise_edge6: in0=%b pend0=%b irq=%b, expected 1 1 1", gin[0], pend[0], irq);
        end
        clr = 4'b0001;
        step();
        clr = 4'b0000;
        vectors++;
        if (pend !== 4'h0 || irq !== 1'b0) begin
            miscompares++;
            $display("FAIL rise_clear: pend=%h irq=%b, expected 0 0", pend, irq);
        end
        ren    = 4'b0000;
        pad[0] = 1'b0;
        for (int k = 0; k < 8; k++) step();
        fen    = 4'b0001;
        pad[0] = 1'b1;
        for (int k = 0; k < 8; k++) step();
        vectors++;
        if (gin[0] !== 1'b1 || pend !== 4'h0 || irq !== 1'b0) begin
            miscompares++;
            $display("FAIL rise_fall_en_only: in0=%b pend=%h irq=%b, expected 1 0 0", gin[0], pend, irq);
        end
    endtask

    task automatic test_glitch();
        ren    = 4'b0010;
        pad[1] = 1'b1;
        for (int k = 0; k < 3; k++) step();
        pad[1] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            vectors++;
            if (gin[1] !== 1'b0 || gin !== m_in) begin
                miscompares++;
                $display("FAIL glitch_%0d: in=%h, expected %h with bit1=0", k, gin, m_in);
            end
        end
        vectors++;
        if (pend !== 4'h0 || irq !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch_pending: pend=%h irq=%b, expected 0 0", pend, irq);
        end
        ren = 4'b0000;
    endtask

    task automatic test_loopback();
        oe   = 4'b0100;
        gout = 4'b0100;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 5) begin
                vectors++;
                if (gin[2] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL loopback_edge5: in2=%b, expected 0", gin[2]);
                end
            end
        end
        vectors++;
        if (gin[2] !== 1'b1 || gin !== m_in) begin
            miscompares++;
            $display("FAIL loopback_edge6: in=%h, expected %h with bit2=1", gin, m_in);
        end
        oe   = 4'b0000;
        gout = 4'b0000;
        for (int k = 0; k < 8; k++) step();
    endtask

    task automatic test_clear_collision();
        pad[0] = 1'b0;
        for (int k = 0; k < 5; k++) step();
        clr = 4'b0001;
        step();
        vectors++;
        if (pend[0] !== 1'b1 || gin[0] !== 1'b0 || irq !== 1'b1) begin
            miscompares++;
            $display("FAIL clear_collision: pend0=%b in0=%b irq=%b, expected 1 0 1", pend[0], gin[0], irq);
        end
        step();
        clr = 4'b0000;
        vectors++;
        if (pend !== 4'h0 || irq !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_lone: pend=%h irq=%b, expected 0 0", pend, irq);
        end
        fen = 4'b0000;
    endtask

    task automatic test_reset_mid();
        pad[3] = 1'b1;
        for (int k = 0; k < 4; k++) step();
        vectors++;
        if (gin[3] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_pre: in3=%b, expected 0", gin[3]);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            vectors++;
            if (gin[3] !== (k == 6 ? 1'b1 : 1'b0) || gin !== m_in) begin
                miscompares++;
                $display("FAIL reset_mid_%0d: in=%h, expected %h bit3=%b", k, gin, m_in, (k == 6));
            end
        end
    endtask

    task automatic test_random();
        int hold;
        for (int seg = 0; seg < 120; seg++) begin
            pad  = W'($urandom);
            hold = $urandom_range(1, 8);
            if ($urandom_range(0, 3) == 0) begin
                oe   = W'($urandom);
                gout = W'($urandom);
                ren  = W'($urandom);
                fen  = W'($urandom);
            end
            for (int k = 0; k < hold; k++) begin
                clr   = ($urandom_range(0, 4) == 0) ? W'($urandom) : '0;
                reset = ($urandom_range(0, 60) == 0);
                step();
                vectors++;
                if (gin !== m_in || pend !== m_pend || irq !== (|m_pend)) begin
                    miscompares++;
                    $display("FAIL random_seg%0d: in=%h pend=%h irq=%b, expected %h %h %b", seg, gin, pend, irq, m_in, m_pend, |m_pend);
                end
            end
        end
        reset = 1'b0;
        clr   = '0;
    endtask

    initial begin
        reset = 1'b1;
        pad   = '0;
        gout  = '0;
        oe    = '0;
        ren   = '0;
        fen   = '0;
        clr   = '0;
        test_reset();
        test_rise();
        test_glitch();
        test_loopback();
        test_clear_collision();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gpio_conditioner.md
GPIO_CONDITIONER -- requirements
Module: gpio_conditioner

Interface
REQ-001 SHALL have parameter GPIO_WIDTH, default 8, number of GPIO channels (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth (>=2).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 16, consecutive cycles a new level must persist (>=1).
REQ-004 SHALL have port clock  input  1  the only clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port gpio_pad_in  input  GPIO_WIDTH  raw asynchronous pad levels.
REQ-007 SHALL have port gpio_output  input  GPIO_WIDTH  values driven by the core.
REQ-008 SHALL have port gpio_oe  input  GPIO_WIDTH  per-pin output enable; 1 means the pin is an output.
REQ-009 SHALL have port irq_rise_en  input  GPIO_WIDTH  per-pin rising-edge interrupt enable.
REQ-010 SHALL have port irq_fall_en  input  GPIO_WIDTH  per-pin falling-edge interrupt enable.
REQ-011 SHALL have port irq_clear  input  GPIO_WIDTH  one-cycle per-pin pending-clear strobes.
REQ-012 SHALL have port gpio_input  output  GPIO_WIDTH  debounced pin levels to the core.
REQ-013 SHALL have port irq_pending  output  GPIO_WIDTH  sticky per-pin interrupt flags.
REQ-014 SHALL have port irq  output  1  OR of irq_pending.

Function
REQ-015 Per pin, the raw level SHALL be gpio_output[i] when gpio_oe[i]=1 (loopback), else gpio_pad_in[i]; the mux sits before the synchroniser.
REQ-016 The raw level SHALL pass through SYNC_STAGES flops; the last stage is the sync level.
REQ-017 Per pin, a counter of width clog2(DEBOUNCE_CYCLES+1) and a stable bit SHALL be kept; gpio_input[i] = stable bit.
REQ-018 Each edge where sync == stable: counter SHALL be cleared.
REQ-019 Each edge where sync != stable and counter == DEBOUNCE_CYCLES-1: stable SHALL toggle and counter SHALL clear; otherwise counter SHALL increment.
REQ-020 A level held constant on the raw input SHALL appear on gpio_input exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges later; any shorter pulse SHALL not change gpio_input.
REQ-021 A stable 0->1 toggle SHALL be a rise event; 1->0 a fall event; events are evaluated on the same edge the stable bit toggles.
REQ-022 irq_pending[i] SHALL set on the edge of a rise event with irq_rise_en[i]=1 or a fall event with irq_fall_en[i]=1.
REQ-023 irq_pending[i] SHALL clear on an edge with irq_clear[i]=1 and no qualifying event; on simultaneous set and clear, set SHALL win.
REQ-024 Deasserting an enable SHALL not clear an already-pending flag; events with enable low SHALL be discarded, not latched.
REQ-025 irq SHALL be the combinational OR of the irq_pending register bits (no added latency).
REQ-026 Channels SHALL be fully independent; no cross-pin interaction.

Reset
REQ-027 On reset: synchroniser flops, counters, stable bits, irq_pending SHALL be 0; hence gpio_input=0, irq_pending=0, irq=0 the edge after reset.
REQ-028 Reset mid-debounce SHALL discard partial count; counting restarts from zero after release.
REQ-029 A pin high at reset release SHALL generate a rise event after SYNC_STAGES+DEBOUNCE_CYCLES edges (defined, firmware-visible behaviour).

Structure
REQ-030 No shared package SHALL be needed; counter width is derived locally from DEBOUNCE_CYCLES.
REQ-031 Per-pin logic SHALL live in sub-module gpio_conditioner_channel, instantiated GPIO_WIDTH times via generate; top holds only instances and the irq OR.
REQ-032 Illegal parameters (SYNC_STAGES<2, DEBOUNCE_CYCLES<1) SHALL be flagged by an elaboration-time check.

Verification (GPIO_WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
REQ-033 Reset with pads=4'hF held -> all outputs 0 one edge after reset; gpio_input=4'hF exactly 6 edges after release.
REQ-034 pad[0] 0->1 held, irq_rise_en[0]=1 -> gpio_input[0], irq_pending[0], irq all rise on edge 6; with irq_fall_en only, no pending.
REQ-035 pad[1] high for 3 cycles then low -> gpio_input[1] stays 0, irq_pending stays 0.
REQ-036 gpio_oe[2]=1, gpio_output[2]=1, pad[2]=0 -> gpio_input[2]=1 on edge 6.
REQ-037 irq_clear[0] coincident with a new fall event on pin 0 (fall_en=1) -> pending stays 1; lone clear next cycle -> pending 0, irq 0.
REQ-038 pad[3] high, reset pulsed at debounce count 2 -> gpio_input[3]=0 until 6 edges after reset release.
